rpn_stack_ctrl: RTL and testbench

Reverse-Polish evaluation controller that sits directly upstream of the 16×8 stack buffer and is also the only consumer of its popped data. It accepts a stream of operand/operator tokens over a valid/ready handshake and drives the stack's push, pop and write data. It reads popped operands back from the stack's registered output, computes, and pushes the result. Each result is also reported on a one-cycle result strobe.

---
 rtl/rpn_stack_ctrl.sv | 173 +++++++++++++++++
 tb/tb_rpn_stack_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_ctrl.sv
// rpn_stack_ctrl: Reverse-Polish token evaluator driving a 16x8 stack buffer.
// Optional multiply opcode (101) is enabled by defining RPN_MUL_EN.
module rpn_stack_ctrl #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  // Token handshake: a token transfers on a rising edge where tok_valid and
  // tok_ready are both 1; tok_valid/tok_is_op/tok_data must be held until then.
  input  logic          tok_valid,
  output logic          tok_ready,
  input  logic          tok_is_op,
  input  logic [DW-1:0] tok_data,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [DW-1:0] stk_din,
  input  logic [DW-1:0] stk_dout,
  input  logic          stk_full,
  input  logic [4:0]    stk_size,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  output logic          err_valid,
  output logic [1:0]    err_code,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PUSH_V = 3'd1,
    POP_B  = 3'd2,
    POP_A  = 3'd3,
    EXEC   = 3'd4,
    PUSH_R = 3'd5
  } state_t;

`ifdef RPN_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  state_t        state_q, state_d;
  logic          push_q, push_d;
  logic          pop_q, pop_d;
  logic [DW-1:0] din_q, din_d;
  logic          res_valid_q, res_valid_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic          err_valid_q, err_valid_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [2:0]    op_q, op_d;
  logic [DW-1:0] b_q, b_d;

  logic          op_legal;
  logic [DW-1:0] alu;

  assign tok_ready = rst && (state_q == IDLE);

  always_comb begin
    case (tok_data[2:0])
      3'b110, 3'b111: op_legal = 1'b0;
      3'b101:         op_legal = MUL_EN;
      default:        op_legal = 1'b1;
    endcase
  end

  // Operand a arrives on stk_dout during EXEC; b was captured one cycle earlier.
  always_comb begin
    case (op_q)
      3'b000:  alu = stk_dout + b_q;
      3'b001:  alu = stk_dout - b_q;
      3'b010:  alu = stk_dout & b_q;
      3'b011:  alu = stk_dout | b_q;
      3'b100:  alu = stk_dout ^ b_q;
`ifdef RPN_MUL_EN
      3'b101:  alu = stk_dout * b_q;
`endif
      default: alu = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    push_d      = 1'b0;
    pop_d       = 1'b0;
    din_d       = din_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    op_d        = op_q;
    b_d         = b_q;
    case (state_q)
      IDLE: begin
        if (tok_valid && tok_ready) begin
          if (!tok_is_op) begin
            if (stk_full) begin
              err_valid_d = 1'b1;
              err_code_d  = 2'b01;
            end else begin
              push_d  = 1'b1;
              din_d   = tok_data;
              state_d = PUSH_V;
            end
          end else if (!op_legal) begin
            err_valid_d = 1'b1;
            err_code_d  = 2'b11;
          end else if (stk_size < 5'd2) begin
            err_valid_d = 1'b1;
            err_code_d  = 2'b10;
          end else begin
            op_d    = tok_data[2:0];
            pop_d   = 1'b1;
            state_d = POP_B;
          end
        end
      end
      PUSH_V: state_d = IDLE;
      POP_B: begin
        pop_d   = 1'b1;
        state_d = POP_A;
      end
      POP_A: begin
        b_d     = stk_dout;
        state_d = EXEC;
      end
      EXEC: begin
        push_d      = 1'b1;
        din_d       = alu;
        res_valid_d = 1'b1;
        res_data_d  = alu;
        state_d     = PUSH_R;
      end
      PUSH_R:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      din_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'b00;
      op_q        <= 3'b000;
      b_q         <= '0;
    end else begin
      state_q     <= state_d;
      push_q      <= push_d;
      pop_q       <= pop_d;
      din_q       <= din_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      op_q        <= op_d;
      b_q         <= b_d;
    end
  end

  assign stk_push  = push_q;
  assign stk_pop   = pop_q;
  assign stk_din   = din_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Bench for rpn_stack_ctrl: stack buffer model, RPN reference evaluator, scoreboards.
module tb_rpn_stack_ctrl;

`ifdef RPN_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       tok_valid;
  logic       tok_ready;
  logic       tok_is_op;
  logic [7:0] tok_data;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_din;
  logic [7:0] stk_dout;
  logic       stk_full;
  logic [4:0] stk_size;
  logic       res_valid;
  logic [7:0] res_data;
  logic       err_valid;
  logic [1:0] err_code;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  int         ref_stk[$];
  logic [7:0] exp_q[$];
  logic [1:0] err_q[$];

  rpn_stack_ctrl #(.DW(8)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_is_op(tok_is_op), .tok_data(tok_data),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
    .stk_dout(stk_dout), .stk_full(stk_full), .stk_size(stk_size),
    .res_valid(res_valid), .res_data(res_data),
    .err_valid(err_valid), .err_code(err_code),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16x8 stack buffer with registered read data, reset from the inverted rst
  logic [7:0] mem [16];
  logic [4:0] sp;
  always @(posedge clk) begin
    if (!rst) begin
      sp       <= 5'd0;
      stk_dout <= 8'd0;
    end else if (stk_push && sp < 5'd16) begin
      mem[sp[3:0]] <= stk_din;
      sp           <= sp + 5'd1;
    end else if (stk_pop && sp > 5'd0) begin
      stk_dout <= mem[sp[3:0] - 4'd1];
      sp       <= sp - 5'd1;
    end
  end
  assign stk_size = sp;
  assign stk_full = (sp == 5'd16);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // reference RPN evaluator
  task automatic model_token(input logic is_op, input logic [7:0] d);
    int a, b, r, op;
    if (!is_op) begin
      if (ref_stk.size() >= 16) err_q.push_back(2'b01);
      else ref_stk.push_back(int'(d));
    end else begin
      op = int'(d[2:0]);
      if (op >= 6 || (op == 5 && !MUL_EN)) err_q.push_back(2'b11);
      else if (ref_stk.size() < 2) err_q.push_back(2'b10);
      else begin
        b = ref_stk.pop_back();
        a = ref_stk.pop_back();
        case (op)
          0:       r = (a + b) % 256;
          1:       r = (a - b + 256) % 256;
          2:       r = a & b;
          3:       r = a | b;
          4:       r = a ^ b;
          default: r = (a * b) % 256;
        endcase
        ref_stk.push_back(r);
        exp_q.push_back(8'(r));
      end
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (stk_push || stk_pop) check_eq("push_pop_excl", {31'd0, stk_push & stk_pop}, 32'd0);
    if (res_valid) begin
      if (exp_q.size() == 0) check_eq("res_unexpected", {31'd0, res_valid}, 32'd0);
      else check_eq("res_data", {24'd0, res_data}, {24'd0, exp_q.pop_front()});
    end
    if (err_valid) begin
      if (err_q.size() == 0) check_eq("err_unexpected", {31'd0, err_valid}, 32'd0);
      else check_eq("err_code", {30'd0, err_code}, {30'd0, err_q.pop_front()});
    end
  end

  // driver tasks
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!tok_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq("ready_timeout", {31'd0, tok_ready}, 32'd1);
  endtask

  task automatic drive_tok(input logic is_op, input logic [7:0] d);
    wait_ready();
    tok_valid = 1'b1;
    tok_is_op = is_op;
    tok_data  = d;
    model_token(is_op, d);
    @(posedge clk);
    #1 tok_valid = 1'b0;
  endtask

  task automatic check_size();
    wait_ready();
    check_eq("stk_size", {27'd0, stk_size}, 32'(ref_stk.size()));
  endtask

  // accepted at edge t; cycle c is the c-th cycle after t
  task automatic send_timed(input logic is_op, input logic [7:0] d);
    drive_tok(is_op, d);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (!is_op) begin
        if (c <= 2) begin
          check_eq("opnd_push_t", {31'd0, stk_push}, {31'd0, c == 1});
          check_eq("opnd_ready_t", {31'd0, tok_ready}, {31'd0, c == 2});
        end
      end else begin
        check_eq("op_pop_t", {31'd0, stk_pop}, {31'd0, (c == 1 || c == 2)});
        check_eq("op_push_t", {31'd0, stk_push}, {31'd0, c == 4});
        check_eq("op_resv_t", {31'd0, res_valid}, {31'd0, c == 4});
        check_eq("op_ready_t", {31'd0, tok_ready}, {31'd0, c == 5});
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    ref_stk.delete();
    exp_q.delete();
    err_q.delete();
    rst = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_push"},  {31'd0, stk_push}, 32'd0);
    check_eq({tag, "_pop"},   {31'd0, stk_pop}, 32'd0);
    check_eq({tag, "_din"},   {24'd0, stk_din}, 32'd0);
    check_eq({tag, "_resv"},  {31'd0, res_valid}, 32'd0);
    check_eq({tag, "_resd"},  {24'd0, res_data}, 32'd0);
    check_eq({tag, "_errv"},  {31'd0, err_valid}, 32'd0);
    check_eq({tag, "_errc"},  {30'd0, err_code}, 32'd0);
    check_eq({tag, "_ready"}, {31'd0, tok_ready}, 32'd0);
    check_eq({tag, "_state"}, {29'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    tok_valid = 1'b0;
    tok_is_op = 1'b0;
    tok_data  = 8'd0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    check_eq("ready_after_reset", {31'd0, tok_ready}, 32'd1);

    // basic ADD with timing
    check_size();
    send_timed(1'b0, 8'd3);
    check_size();
    send_timed(1'b0, 8'd5);
    check_size();
    send_timed(1'b1, 8'd0);
    check_size();

    // SUB wrap / operand order
    do_reset();
    drive_tok(1'b0, 8'd2);
    drive_tok(1'b0, 8'd7);
    drive_tok(1'b1, 8'd1);
    check_size();

    // overflow
    do_reset();
    for (int i = 0; i < 16; i++) drive_tok(1'b0, 8'(i * 17));
    check_size();
    drive_tok(1'b0, 8'hAA);
    @(negedge clk);
    check_eq("ovf_no_push", {31'd0, stk_push}, 32'd0);
    check_size();

    // underflow and illegal opcode
    do_reset();
    drive_tok(1'b0, 8'd9);
    drive_tok(1'b1, 8'd0);
    check_size();
    drive_tok(1'b1, 8'd7);
    check_size();
    drive_tok(1'b1, 8'd6);
    check_size();

    // reset during POP_A drops the operator
    do_reset();
    drive_tok(1'b0, 8'd4);
    drive_tok(1'b0, 8'd9);
    wait_ready();
    tok_valid = 1'b1;
    tok_is_op = 1'b1;
    tok_data  = 8'd0;
    @(posedge clk);
    #1 tok_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("midop");
    ref_stk.delete();
    @(negedge clk);
    check_eq("midop_push", {31'd0, stk_push}, 32'd0);
    rst = 1'b1;
    drive_tok(1'b0, 8'd1);
    drive_tok(1'b0, 8'd1);
    drive_tok(1'b1, 8'd0);
    check_size();

    // MUL configuration
    do_reset();
    drive_tok(1'b0, 8'd20);
    drive_tok(1'b0, 8'd13);
    drive_tok(1'b1, 8'd5);
    check_size();

    // randomized token stream
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < ((i < 200) ? 70 : 35))
        drive_tok(1'b0, 8'($urandom_range(255)));
      else
        drive_tok(1'b1, {5'($urandom_range(31)), 3'($urandom_range(7))});
      if ($urandom_range(3) == 0) check_size();
      repeat ($urandom_range(2)) @(negedge clk);
    end
    check_size();
    repeat (10) @(negedge clk);
    check_eq("res_pending", 32'(exp_q.size()), 32'd0);
    check_eq("err_pending", 32'(err_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
